// File: rtl/prog_launcher_if.sv
// Handshake bundle between the program launcher (master) and its environment (slave).
interface prog_launcher_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
) ();
    logic             go;
    logic             ack;
    logic             start;
    logic [PC_W-1:0]  start_pc;
    logic [1:0]       prog_idx;
    logic             busy;
    logic [CNT_W-1:0] cycle_cnt;
    logic             cnt_valid;
    logic             all_done;
    logic             error;

    modport master (
        input  go, ack,
        output start, start_pc, prog_idx, busy, cycle_cnt, cnt_valid, all_done, error
    );

    modport slave (
        output go, ack,
        input  start, start_pc, prog_idx, busy, cycle_cnt, cnt_valid, all_done, error
    );
endinterface

// File: rtl/prog_launcher.sv
// Sequences programs 0..NUM_PROGS-1: Start pulse, wait for a fresh Ack edge, count cycles,
// flag a timeout. All outputs come straight from registers.
module prog_launcher #(
    parameter int unsigned NUM_PROGS = 3,
    parameter int unsigned PC_W      = 10,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned START_LEN = 2,
    parameter int unsigned GAP_LEN   = 1,
    parameter int unsigned TIMEOUT   = 50000,
    parameter int unsigned PC0       = 0,
    parameter int unsigned PC1       = 256,
    parameter int unsigned PC2       = 512,
    parameter int unsigned PC3       = 768
) (
    input logic             i_clk,
    input logic             i_rst,
    prog_launcher_if.master io_bus
);
    typedef enum logic [2:0] {StIdle, StStart, StRun, StGap, StFinish, StError} state_e;

    localparam logic [1:0]       LAST_IDX    = 2'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_LEN);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e           r_state, w_state_d;
    logic             r_go_q, r_ack_q;
    logic [CNT_W-1:0] r_phase, w_phase_d;
    logic [CNT_W-1:0] r_run_cnt, w_run_cnt_d;
    logic             r_start, w_start_d;
    logic [PC_W-1:0]  r_start_pc, w_start_pc_d;
    logic [1:0]       r_prog_idx, w_prog_idx_d;
    logic             r_busy, w_busy_d;
    logic [CNT_W-1:0] r_cycle_cnt, w_cycle_cnt_d;
    logic             r_cnt_valid, w_cnt_valid_d;
    logic             r_all_done, w_all_done_d;
    logic             r_error, w_error_d;

    logic             w_go_rise, w_ack_rise;
    logic [CNT_W-1:0] w_run_inc;
    logic [1:0]       w_next_idx;

    function automatic logic [PC_W-1:0] pc_of(input logic [1:0] idx);
        unique case (idx)
            2'd0: pc_of = PC_W'(PC0);
            2'd1: pc_of = PC_W'(PC1);
            2'd2: pc_of = PC_W'(PC2);
            2'd3: pc_of = PC_W'(PC3);
        endcase
    endfunction

    assign w_go_rise  = io_bus.go & ~r_go_q;
    assign w_ack_rise = io_bus.ack & ~r_ack_q;
    assign w_run_inc  = (&r_run_cnt) ? r_run_cnt : r_run_cnt + CNT_W'(1);
    assign w_next_idx = r_prog_idx + 2'd1;

    always_comb begin
        w_state_d     = r_state;
        w_phase_d     = r_phase;
        w_run_cnt_d   = r_run_cnt;
        w_start_d     = r_start;
        w_start_pc_d  = r_start_pc;
        w_prog_idx_d  = r_prog_idx;
        w_busy_d      = r_busy;
        w_cycle_cnt_d = r_cycle_cnt;
        w_cnt_valid_d = 1'b0;
        w_all_done_d  = r_all_done;
        w_error_d     = r_error;
        unique case (r_state)
            StIdle, StFinish, StError: begin
                if (w_go_rise) begin
                    w_state_d    = StStart;
                    w_phase_d    = '0;
                    w_start_d    = 1'b1;
                    w_start_pc_d = pc_of(2'd0);
                    w_prog_idx_d = 2'd0;
                    w_busy_d     = 1'b1;
                    w_all_done_d = 1'b0;
                    w_error_d    = 1'b0;
                end
            end
            StStart: begin
                if (r_phase == START_LAST) begin
                    w_state_d   = StRun;
                    w_start_d   = 1'b0;
                    w_run_cnt_d = '0;
                end else begin
                    w_phase_d = r_phase + CNT_W'(1);
                end
            end
            StRun: begin
                w_run_cnt_d = w_run_inc;
                // The Ack cycle itself is counted, and an Ack on the timeout cycle still wins.
                if (w_ack_rise) begin
                    w_cycle_cnt_d = w_run_inc;
                    w_cnt_valid_d = 1'b1;
                    if (r_prog_idx == LAST_IDX) begin
                        w_state_d    = StFinish;
                        w_busy_d     = 1'b0;
                        w_all_done_d = 1'b1;
                    end else begin
                        w_state_d = StGap;
                        w_phase_d = '0;
                        if (GAP_LEN == 0) begin
                            w_prog_idx_d = w_next_idx;
                            w_start_pc_d = pc_of(w_next_idx);
                        end
                    end
                end else if (w_run_inc >= TIMEOUT_CNT) begin
                    w_state_d = StError;
                    w_busy_d  = 1'b0;
                    w_error_d = 1'b1;
                end
            end
            StGap: begin
                // StartPC moves on the edge entering the last gap cycle, one cycle ahead of Start.
                if (r_phase == GAP_LAST) begin
                    w_state_d = StStart;
                    w_phase_d = '0;
                    w_start_d = 1'b1;
                end else begin
                    w_phase_d = r_phase + CNT_W'(1);
                    if (r_phase + CNT_W'(1) == GAP_LAST) begin
                        w_prog_idx_d = w_next_idx;
                        w_start_pc_d = pc_of(w_next_idx);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_go_q      <= 1'b0;
            r_ack_q     <= 1'b0;
            r_phase     <= '0;
            r_run_cnt   <= '0;
            r_start     <= 1'b0;
            r_start_pc  <= PC_W'(PC0);
            r_prog_idx  <= 2'd0;
            r_busy      <= 1'b0;
            r_cycle_cnt <= '0;
            r_cnt_valid <= 1'b0;
            r_all_done  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_go_q      <= io_bus.go;
            r_ack_q     <= io_bus.ack;
            r_phase     <= w_phase_d;
            r_run_cnt   <= w_run_cnt_d;
            r_start     <= w_start_d;
            r_start_pc  <= w_start_pc_d;
            r_prog_idx  <= w_prog_idx_d;
            r_busy      <= w_busy_d;
            r_cycle_cnt <= w_cycle_cnt_d;
            r_cnt_valid <= w_cnt_valid_d;
            r_all_done  <= w_all_done_d;
            r_error     <= w_error_d;
        end
    end

    assign io_bus.start     = r_start;
    assign io_bus.start_pc  = r_start_pc;
    assign io_bus.prog_idx  = r_prog_idx;
    assign io_bus.busy      = r_busy;
    assign io_bus.cycle_cnt = r_cycle_cnt;
    assign io_bus.cnt_valid = r_cnt_valid;
    assign io_bus.all_done  = r_all_done;
    assign io_bus.error     = r_error;
endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: three instances cover default, short-timeout and
// minimum-timing parameter sets; sel picks which one the stimulus and monitors address.
module tb_prog_launcher;
    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic go;
    logic ack;
    int   sel;
    int   n_chk;
    int   n_fail;

    logic             m_start, m_busy, m_cnt_valid, m_all_done, m_error;
    logic [PC_W-1:0]  m_pc;
    logic [1:0]       m_idx;
    logic [CNT_W-1:0] m_cnt;

    prog_launcher_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus_a ();
    prog_launcher_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus_t ();
    prog_launcher_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus_f ();

    assign bus_a.go  = go & (sel == 0);
    assign bus_a.ack = ack & (sel == 0);
    assign bus_t.go  = go & (sel == 1);
    assign bus_t.ack = ack & (sel == 1);
    assign bus_f.go  = go & (sel == 2);
    assign bus_f.ack = ack & (sel == 2);

    prog_launcher #(.PC_W(PC_W), .CNT_W(CNT_W)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .io_bus(bus_a)
    );
    prog_launcher #(.PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT(20)) u_dut_t (
        .i_clk(clk), .i_rst(rst), .io_bus(bus_t)
    );
    prog_launcher #(.PC_W(PC_W), .CNT_W(CNT_W), .START_LEN(1), .GAP_LEN(0)) u_dut_f (
        .i_clk(clk), .i_rst(rst), .io_bus(bus_f)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_start = bus_a.start; m_busy = bus_a.busy; m_cnt_valid = bus_a.cnt_valid;
        m_all_done = bus_a.all_done; m_error = bus_a.error; m_pc = bus_a.start_pc;
        m_idx = bus_a.prog_idx; m_cnt = bus_a.cycle_cnt;
        if (sel == 1) begin
            m_start = bus_t.start; m_busy = bus_t.busy; m_cnt_valid = bus_t.cnt_valid;
            m_all_done = bus_t.all_done; m_error = bus_t.error; m_pc = bus_t.start_pc;
            m_idx = bus_t.prog_idx; m_cnt = bus_t.cycle_cnt;
        end else if (sel == 2) begin
            m_start = bus_f.start; m_busy = bus_f.busy; m_cnt_valid = bus_f.cnt_valid;
            m_all_done = bus_f.all_done; m_error = bus_f.error; m_pc = bus_f.start_pc;
            m_idx = bus_f.prog_idx; m_cnt = bus_f.cycle_cnt;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int s);
        sel = s;
        go  = 1'b0;
        ack = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    // Bounded wait for a Start pulse; reports StartPC one sample before the rise.
    task automatic wait_start(output bit ok, output logic [PC_W-1:0] pre_pc,
                              output logic [PC_W-1:0] rise_pc, output logic [1:0] rise_idx,
                              output int hi_len);
        int k;
        k = 0;
        hi_len = 0;
        pre_pc = m_pc;
        while (m_start !== 1'b1 && k < 40) begin
            pre_pc = m_pc;
            cyc(1);
            k++;
        end
        rise_pc  = m_pc;
        rise_idx = m_idx;
        while (m_start === 1'b1 && k < 80) begin
            hi_len++;
            cyc(1);
            k++;
        end
        ok = (m_start === 1'b0) && (hi_len > 0);
    endtask

    // Ack is sampled n edges after the edge on which Start fell.
    task automatic run_prog(input int n, input bit keep_ack, output bit ok,
                            output logic [PC_W-1:0] pre_pc, output logic [PC_W-1:0] rise_pc,
                            output logic [1:0] rise_idx, output int hi_len,
                            output logic [CNT_W-1:0] cnt, output logic valid);
        wait_start(ok, pre_pc, rise_pc, rise_idx, hi_len);
        cyc(n - 1);
        ack = 1'b1;
        cyc(1);
        cnt   = m_cnt;
        valid = m_cnt_valid;
        if (!keep_ack) ack = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0; go = 1'b0; ack = 1'b0; rst = 1'b1;
        cyc(2);
        n_chk++; if (m_start !== 1'b0) begin n_fail++; $display("FAIL rst_start got=%b exp=0", m_start); end
        n_chk++; if (m_pc !== 10'd0) begin n_fail++; $display("FAIL rst_pc got=%0d exp=0", m_pc); end
        n_chk++; if (m_idx !== 2'd0) begin n_fail++; $display("FAIL rst_idx got=%0d exp=0", m_idx); end
        n_chk++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", m_busy); end
        n_chk++; if (m_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", m_cnt); end
        n_chk++; if (m_cnt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", m_cnt_valid); end
        n_chk++; if (m_all_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", m_all_done); end
        n_chk++; if (m_error !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", m_error); end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_normal();
        bit ok; logic [PC_W-1:0] pre, rise; logic [1:0] idx; int hi; logic [CNT_W-1:0] cnt;
        logic v;
        int lens [3];
        logic [PC_W-1:0] pcs [3];
        lens = '{40, 100, 7};
        pcs  = '{10'd0, 10'd256, 10'd512};
        do_reset(0);
        go = 1'b1;
        for (int p = 0; p < 3; p++) begin
            run_prog(lens[p], 1'b0, ok, pre, rise, idx, hi, cnt, v);
            go = 1'b0;
            n_chk++; if (!ok) begin n_fail++; $display("FAIL t2_start p=%0d got=no_pulse exp=pulse", p); end
            n_chk++; if (rise !== pcs[p]) begin n_fail++; $display("FAIL t2_pc p=%0d got=%0d exp=%0d", p, rise, pcs[p]); end
            n_chk++; if (idx !== 2'(p)) begin n_fail++; $display("FAIL t2_idx p=%0d got=%0d exp=%0d", p, idx, p); end
            n_chk++; if (hi != 2) begin n_fail++; $display("FAIL t2_startlen p=%0d got=%0d exp=2", p, hi); end
            n_chk++; if (cnt !== 16'(lens[p])) begin n_fail++; $display("FAIL t2_cnt p=%0d got=%0d exp=%0d", p, cnt, lens[p]); end
            n_chk++; if (v !== 1'b1) begin n_fail++; $display("FAIL t2_valid p=%0d got=%b exp=1", p, v); end
            if (p > 0) begin
                n_chk++; if (pre !== pcs[p]) begin n_fail++; $display("FAIL t2_pc_early p=%0d got=%0d exp=%0d", p, pre, pcs[p]); end
            end
        end
        n_chk++; if (m_all_done !== 1'b1) begin n_fail++; $display("FAIL t2_done got=%b exp=1", m_all_done); end
        n_chk++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL t2_busy got=%b exp=0", m_busy); end
        cyc(1);
        n_chk++; if (m_cnt_valid !== 1'b0) begin n_fail++; $display("FAIL t2_valid_pulse got=%b exp=0", m_cnt_valid); end
        n_chk++; if (m_idx !== 2'd2) begin n_fail++; $display("FAIL t2_last_idx got=%0d exp=2", m_idx); end
    endtask

    task automatic test_mid_reset();
        bit ok; logic [PC_W-1:0] pre, rise; logic [1:0] idx; int hi; logic [CNT_W-1:0] cnt;
        logic v;
        do_reset(0);
        go = 1'b1;
        run_prog(5, 1'b0, ok, pre, rise, idx, hi, cnt, v);
        go = 1'b0;
        wait_start(ok, pre, rise, idx, hi);
        cyc(3);
        n_chk++; if (m_idx !== 2'd1 || m_busy !== 1'b1) begin n_fail++; $display("FAIL t1_in_run got=idx%0d/busy%b exp=idx1/busy1", m_idx, m_busy); end
        rst = 1'b1;
        #2;
        n_chk++; if (m_start !== 1'b0) begin n_fail++; $display("FAIL t1_start got=%b exp=0", m_start); end
        n_chk++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy got=%b exp=0", m_busy); end
        n_chk++; if (m_idx !== 2'd0) begin n_fail++; $display("FAIL t1_idx got=%0d exp=0", m_idx); end
        n_chk++; if (m_pc !== 10'd0) begin n_fail++; $display("FAIL t1_pc got=%0d exp=0", m_pc); end
        n_chk++; if (m_cnt !== 16'd0) begin n_fail++; $display("FAIL t1_cnt got=%0d exp=0", m_cnt); end
        cyc(2);
        rst = 1'b0;
        go  = 1'b1;
        cyc(1);
        go  = 1'b0;
        n_chk++; if (m_start !== 1'b1) begin n_fail++; $display("FAIL t1_restart got=%b exp=1", m_start); end
        n_chk++; if (m_idx !== 2'd0 || m_pc !== 10'd0) begin n_fail++; $display("FAIL t1_restart_pc got=idx%0d/pc%0d exp=idx0/pc0", m_idx, m_pc); end
    endtask

    task automatic test_stale_ack();
        bit ok; logic [PC_W-1:0] pre, rise; logic [1:0] idx; int hi; logic [CNT_W-1:0] cnt;
        logic v;
        bit saw;
        do_reset(0);
        go = 1'b1;
        run_prog(10, 1'b1, ok, pre, rise, idx, hi, cnt, v);
        go = 1'b0;
        n_chk++; if (cnt !== 16'd10) begin n_fail++; $display("FAIL t3_cnt0 got=%0d exp=10", cnt); end
        wait_start(ok, pre, rise, idx, hi);
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            if (m_cnt_valid !== 1'b0) saw = 1'b1;
        end
        n_chk++; if (saw) begin n_fail++; $display("FAIL t3_stale got=valid exp=no_valid"); end
        n_chk++; if (m_idx !== 2'd1 || m_busy !== 1'b1) begin n_fail++; $display("FAIL t3_hold got=idx%0d/busy%b exp=idx1/busy1", m_idx, m_busy); end
        ack = 1'b0;
        cyc(1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        n_chk++; if (m_cnt !== 16'd17 || m_cnt_valid !== 1'b1) begin n_fail++; $display("FAIL t3_cnt1 got=%0d/%b exp=17/1", m_cnt, m_cnt_valid); end
        run_prog(3, 1'b0, ok, pre, rise, idx, hi, cnt, v);
        n_chk++; if (cnt !== 16'd3 || m_all_done !== 1'b1) begin n_fail++; $display("FAIL t3_end got=%0d/%b exp=3/1", cnt, m_all_done); end
    endtask

    task automatic test_ignored_go();
        bit ok; logic [PC_W-1:0] pre, rise; logic [1:0] idx; int hi; logic [CNT_W-1:0] cnt;
        logic v;
        do_reset(0);
        go = 1'b1;
        wait_start(ok, pre, rise, idx, hi);
        go = 1'b0;
        cyc(5);
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        n_chk++; if (m_start !== 1'b0 || m_idx !== 2'd0 || m_busy !== 1'b1) begin n_fail++; $display("FAIL t5_run got=start%b/idx%0d/busy%b exp=start0/idx0/busy1", m_start, m_idx, m_busy); end
        cyc(13);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        n_chk++; if (m_cnt !== 16'd20) begin n_fail++; $display("FAIL t5_cnt got=%0d exp=20", m_cnt); end
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        n_chk++; if (m_start !== 1'b0 || m_idx !== 2'd1) begin n_fail++; $display("FAIL t5_gap got=start%b/idx%0d exp=start0/idx1", m_start, m_idx); end
        run_prog(4, 1'b0, ok, pre, rise, idx, hi, cnt, v);
        n_chk++; if (rise !== 10'd256 || cnt !== 16'd4) begin n_fail++; $display("FAIL t5_p1 got=pc%0d/cnt%0d exp=pc256/cnt4", rise, cnt); end
        run_prog(4, 1'b0, ok, pre, rise, idx, hi, cnt, v);
        n_chk++; if (m_all_done !== 1'b1 || m_idx !== 2'd2) begin n_fail++; $display("FAIL t5_end got=done%b/idx%0d exp=done1/idx2", m_all_done, m_idx); end
    endtask

    task automatic test_timeout();
        bit ok; logic [PC_W-1:0] pre, rise; logic [1:0] idx; int hi; logic [CNT_W-1:0] cnt;
        logic v;
        do_reset(1);
        go = 1'b1;
        run_prog(10, 1'b0, ok, pre, rise, idx, hi, cnt, v);
        go = 1'b0;
        wait_start(ok, pre, rise, idx, hi);
        cyc(19);
        n_chk++; if (m_error !== 1'b0 || m_busy !== 1'b1) begin n_fail++; $display("FAIL t4_early got=err%b/busy%b exp=err0/busy1", m_error, m_busy); end
        cyc(1);
        n_chk++; if (m_error !== 1'b1) begin n_fail++; $display("FAIL t4_err got=%b exp=1", m_error); end
        n_chk++; if (m_idx !== 2'd1 || m_start !== 1'b0) begin n_fail++; $display("FAIL t4_idx got=idx%0d/start%b exp=idx1/start0", m_idx, m_start); end
        n_chk++; if (m_busy !== 1'b0 || m_all_done !== 1'b0) begin n_fail++; $display("FAIL t4_flags got=busy%b/done%b exp=busy0/done0", m_busy, m_all_done); end
        cyc(3);
        n_chk++; if (m_error !== 1'b1) begin n_fail++; $display("FAIL t4_sticky got=%b exp=1", m_error); end
        go = 1'b1;
        cyc(1);
        n_chk++; if (m_error !== 1'b0 || m_start !== 1'b1 || m_idx !== 2'd0 || m_pc !== 10'd0) begin n_fail++; $display("FAIL t4_restart got=err%b/start%b/idx%0d/pc%0d exp=err0/start1/idx0/pc0", m_error, m_start, m_idx, m_pc); end
        run_prog(20, 1'b0, ok, pre, rise, idx, hi, cnt, v);
        go = 1'b0;
        n_chk++; if (cnt !== 16'd20 || v !== 1'b1 || m_error !== 1'b0) begin n_fail++; $display("FAIL t4_ack_wins got=cnt%0d/v%b/err%b exp=cnt20/v1/err0", cnt, v, m_error); end
        run_prog(2, 1'b0, ok, pre, rise, idx, hi, cnt, v);
        run_prog(3, 1'b0, ok, pre, rise, idx, hi, cnt, v);
        n_chk++; if (m_all_done !== 1'b1 || cnt !== 16'd3) begin n_fail++; $display("FAIL t4_end got=done%b/cnt%0d exp=done1/cnt3", m_all_done, cnt); end
    endtask

    task automatic test_edge_timing();
        bit ok; logic [PC_W-1:0] pre, rise; logic [1:0] idx; int hi; logic [CNT_W-1:0] cnt;
        logic v;
        do_reset(2);
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        n_chk++; if (m_start !== 1'b1) begin n_fail++; $display("FAIL t6_rise got=%b exp=1", m_start); end
        cyc(1);
        n_chk++; if (m_start !== 1'b0) begin n_fail++; $display("FAIL t6_len got=%b exp=0", m_start); end
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        n_chk++; if (m_cnt !== 16'd1 || m_cnt_valid !== 1'b1) begin n_fail++; $display("FAIL t6_cnt got=%0d/%b exp=1/1", m_cnt, m_cnt_valid); end
        n_chk++; if (m_start !== 1'b0 || m_idx !== 2'd1 || m_pc !== 10'd256) begin n_fail++; $display("FAIL t6_pc got=start%b/idx%0d/pc%0d exp=start0/idx1/pc256", m_start, m_idx, m_pc); end
        cyc(1);
        n_chk++; if (m_start !== 1'b1) begin n_fail++; $display("FAIL t6_next got=%b exp=1", m_start); end
        cyc(1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        n_chk++; if (m_cnt !== 16'd1) begin n_fail++; $display("FAIL t6_cnt1 got=%0d exp=1", m_cnt); end
        run_prog(1, 1'b0, ok, pre, rise, idx, hi, cnt, v);
        n_chk++; if (rise !== 10'd512 || hi != 1 || cnt !== 16'd1) begin n_fail++; $display("FAIL t6_p2 got=pc%0d/hi%0d/cnt%0d exp=pc512/hi1/cnt1", rise, hi, cnt); end
        n_chk++; if (m_all_done !== 1'b1) begin n_fail++; $display("FAIL t6_done got=%b exp=1", m_all_done); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_normal();
        test_mid_reset();
        test_stale_ack();
        test_ignored_go();
        test_timeout();
        test_edge_timing();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
